// File: rtl/equiv_check_pkg.sv
// equiv_check_pkg: shared types and constants for the equivalence checker.
// Holds the sequencer state encoding, the 16-bit counter type and the
// Galois LFSR feedback masks.
package equiv_check_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    CHECK,
    DONE
  } state_t;

  typedef logic [15:0] count_t;

  localparam count_t COUNT_MAX = 16'hFFFF;

  // Right-shifting Galois mask for x^12 + x^11 + x^10 + x^4 + 1 (period 4095).
  // Tap t of the polynomial maps to mask bit t-1.
  localparam logic [11:0] LFSR_TAPS_12 = 12'hE08;

  // Maximal-length Galois masks for the supported stimulus widths (2..16).
  function automatic logic [31:0] lfsr_taps(input int width);
    logic [31:0] taps;
    case (width)
      2:       taps = 32'h0003;
      3:       taps = 32'h0006;
      4:       taps = 32'h000C;
      5:       taps = 32'h0014;
      6:       taps = 32'h0030;
      7:       taps = 32'h0060;
      8:       taps = 32'h00B8;
      9:       taps = 32'h0110;
      10:      taps = 32'h0240;
      11:      taps = 32'h0500;
      12:      taps = {20'h0, LFSR_TAPS_12};
      13:      taps = 32'h1C80;
      14:      taps = 32'h3802;
      15:      taps = 32'h6000;
      16:      taps = 32'hB400;
      default: taps = {20'h0, LFSR_TAPS_12};
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/equiv_check_lfsr.sv
// equiv_check_lfsr: maximal-length Galois LFSR used as the stimulus source.
// load restarts the sequence from SEED (0 is replaced by 1 so the register
// can never lock up at all-zero); adv steps it once.
module equiv_check_lfsr
  import equiv_check_pkg::*;
#(
  parameter int            W    = 12,
  parameter logic [W-1:0]  SEED = 12'hACE
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;
  localparam logic [W-1:0] TAPS     = W'(lfsr_taps(W));

  // Shift right; fold the feedback mask in whenever a one falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED_EFF;
    end else if (load) begin
      value <= SEED_EFF;
    end else if (adv) begin
      value <= {1'b0, value[W-1:1]} ^ (value[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/equiv_check_seq.sv
// equiv_check_seq: drives pseudo-random stimulus to a spec and an impl
// instance, waits SETTLE cycles, compares every output word and counts
// failing vectors over a run of NUM_VEC vectors.
// Optional feature: define EQUIV_CHECK_SEQ_FIRST_FAIL_EN to capture the
// stimulus and per-word mismatch mask of the first failing vector.
module equiv_check_seq
  import equiv_check_pkg::*;
#(
  parameter int                STIM_W   = 12,
  parameter int                NUM_OUTS = 11,
  parameter int                OUT_W    = 41,
  parameter int                SETTLE   = 1,
  parameter int                NUM_VEC  = 1000,
  parameter logic [STIM_W-1:0] SEED     = 12'hACE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [STIM_W-1:0]          stim,
  input  logic [NUM_OUTS*OUT_W-1:0]  spec_o,
  input  logic [NUM_OUTS*OUT_W-1:0]  impl_o,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output count_t                     vec_count,
  output count_t                     fail_count,
  output logic [STIM_W-1:0]          fail_stim,
  output logic [NUM_OUTS-1:0]        fail_mask
);

  localparam logic [3:0] SETTLE_CNT  = 4'(SETTLE);
  localparam count_t     NUM_VEC_CNT = count_t'(NUM_VEC);

  state_t                state;
  state_t                state_next;
  logic [3:0]            wait_cnt;
  logic [STIM_W-1:0]     lfsr_value;
  logic [NUM_OUTS-1:0]   mismatch;
  logic                  any_mismatch;
  logic                  launch;
  count_t                vec_inc;

  assign launch  = ((state == IDLE) || (state == DONE)) && start;
  assign vec_inc = vec_count + 16'd1;

  equiv_check_lfsr #(
    .W    (STIM_W),
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (launch),
    .adv   (state == DRIVE),
    .value (lfsr_value)
  );

  // Per-word comparator; in simulation X/Z differences count as mismatches.
  for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_cmp
`ifdef SYNTHESIS
    assign mismatch[gi] = impl_o[gi*OUT_W +: OUT_W] != spec_o[gi*OUT_W +: OUT_W];
`else
    assign mismatch[gi] = impl_o[gi*OUT_W +: OUT_W] !== spec_o[gi*OUT_W +: OUT_W];
`endif
  end

  assign any_mismatch = |mismatch;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      state_next = WAIT;
      WAIT:       if (wait_cnt == 4'd1) state_next = CHECK;
      CHECK:      state_next = (vec_inc == NUM_VEC_CNT) ? DONE : DRIVE;
      default:    state_next = IDLE;
    endcase
  end

  // Stimulus register and settle counter; stim only changes in DRIVE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim     <= '0;
      wait_cnt <= '0;
    end else if (state == DRIVE) begin
      stim     <= lfsr_value;
      wait_cnt <= SETTLE_CNT;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Run counters: cleared on an accepted start, updated once per CHECK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_count  <= '0;
      fail_count <= '0;
    end else if (launch) begin
      vec_count  <= '0;
      fail_count <= '0;
    end else if (state == CHECK) begin
      vec_count <= vec_inc;
      if (any_mismatch && (fail_count != COUNT_MAX)) fail_count <= fail_count + 16'd1;
    end
  end

`ifdef EQUIV_CHECK_SEQ_FIRST_FAIL_EN
  // First-failure capture: latches only while no failure has been counted yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_stim <= '0;
      fail_mask <= '0;
    end else if (launch) begin
      fail_stim <= '0;
      fail_mask <= '0;
    end else if ((state == CHECK) && any_mismatch && (fail_count == '0)) begin
      fail_stim <= stim;
      fail_mask <= mismatch;
    end
  end
`else
  assign fail_stim = '0;
  assign fail_mask = '0;
`endif

  assign busy = (state == DRIVE) || (state == WAIT) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (fail_count == '0);

endmodule
